voice_allocator: RTL

- Polyphony scheduler that shares a fixed pool of oscillator voices among keyboard key requesters.
- Scans debounced key levels and assigns a free voice on each press, latching the current waveform selection into that voice.
- Frees the voice on release; when the pool is exhausted, optionally steals the oldest voice.
- Sits between the key/waveform input stage and the per-voice oscillator datapath.

---
 rtl/synth_pkg.sv | 22 ++
 rtl/voice_select.sv | 42 ++++
 rtl/voice_allocator.sv | 123 ++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types for the polyphony scheduler: waveform codes, allocator FSM states.
package synth_pkg;

  typedef enum logic [1:0] {
    SQUARE   = 2'b00,
    TRIANGLE = 2'b01,
    SINE     = 2'b10,
    SAWTOOTH = 2'b11
  } waveform_t;

  typedef enum logic [1:0] {
    S_SCAN,
    S_ALLOC,
    S_RELEASE
  } alloc_state_t;

  // Index width that stays legal for a single-entry pool.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational voice picker: lowest free voice, and oldest voice (lowest index on tie).
module voice_select
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8,
  localparam int VIDX_W    = idx_w(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]       active,
  input  logic [NUM_VOICES*AGE_W-1:0] ages,
  output logic                        free_found,
  output logic [VIDX_W-1:0]           free_idx,
  output logic [VIDX_W-1:0]           oldest_idx
);

  logic [AGE_W-1:0] best_age;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    // Descending scan so the last hit, the lowest index, wins.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = VIDX_W'(i);
      end
    end
  end

  always_comb begin
    oldest_idx = '0;
    best_age   = ages[0 +: AGE_W];
    // Strict compare keeps the lowest index on equal ages.
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (ages[i*AGE_W +: AGE_W] > best_age) begin
        best_age   = ages[i*AGE_W +: AGE_W];
        oldest_idx = VIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: scans keys, allocates/frees oscillator voices, one action per key visit.
// Define VOICE_STEAL_EN to steal the oldest voice when the pool is full; otherwise the press is dropped.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_KEYS   = 13,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = $clog2(NUM_KEYS),
  parameter int AGE_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [NUM_KEYS-1:0]         keys_in,
  input  waveform_t                   waveform_in,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES*2-1:0]     voice_waveform,
  output logic [NUM_VOICES-1:0]       voice_start,
  output logic                        busy
);

  localparam int VIDX_W = idx_w(NUM_VOICES);

  alloc_state_t               state;
  logic [KEY_W-1:0]           ptr;
  logic [KEY_W-1:0]           ptr_next;
  logic [NUM_KEYS-1:0]        key_held;
  logic [NUM_VOICES*AGE_W-1:0] age_q;

  logic              free_found;
  logic [VIDX_W-1:0] free_idx;
  logic [VIDX_W-1:0] oldest_idx;
  logic              alloc_ok;
  logic [VIDX_W-1:0] target;

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W)
  ) u_voice_select (
    .active     (voice_active),
    .ages       (age_q),
    .free_found (free_found),
    .free_idx   (free_idx),
    .oldest_idx (oldest_idx)
  );

`ifdef VOICE_STEAL_EN
  assign alloc_ok = 1'b1;
  assign target   = free_found ? free_idx : oldest_idx;
`else
  logic unused_oldest;
  assign unused_oldest = ^oldest_idx;
  assign alloc_ok      = free_found;
  assign target        = free_idx;
`endif

  assign ptr_next = (ptr == KEY_W'(NUM_KEYS - 1)) ? '0 : ptr + 1'b1;
  assign busy     = (state == S_ALLOC) || (state == S_RELEASE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_SCAN;
      ptr            <= '0;
      key_held       <= '0;
      age_q          <= '0;
      voice_active   <= '0;
      voice_key      <= '0;
      voice_waveform <= '0;
      voice_start    <= '0;
    end else if (!ena) begin
      voice_start <= '0;
    end else begin
      voice_start <= '0;

      // Later assignments in this block override the aging of allocated/released voices.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_active[v] && (age_q[v*AGE_W +: AGE_W] != {AGE_W{1'b1}}))
          age_q[v*AGE_W +: AGE_W] <= age_q[v*AGE_W +: AGE_W] + 1'b1;
      end

      case (state)
        S_SCAN: begin
          if (keys_in[ptr] && !key_held[ptr])
            state <= S_ALLOC;
          else if (!keys_in[ptr] && key_held[ptr])
            state <= S_RELEASE;
          else
            ptr <= ptr_next;
        end

        S_ALLOC: begin
          if (alloc_ok) begin
            voice_active[target]               <= 1'b1;
            voice_key[target*KEY_W +: KEY_W]   <= ptr;
            voice_waveform[target*2 +: 2]      <= waveform_in;
            voice_start[target]                <= 1'b1;
            age_q[target*AGE_W +: AGE_W]       <= '0;
          end
          key_held[ptr] <= 1'b1;
          ptr           <= ptr_next;
          state         <= S_SCAN;
        end

        S_RELEASE: begin
          // No match means the voice was stolen earlier; nothing to free.
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_active[v] && (voice_key[v*KEY_W +: KEY_W] == ptr)) begin
              voice_active[v]         <= 1'b0;
              age_q[v*AGE_W +: AGE_W] <= '0;
            end
          end
          key_held[ptr] <= 1'b0;
          ptr           <= ptr_next;
          state         <= S_SCAN;
        end

        default: state <= S_SCAN;
      endcase
    end
  end

endmodule
